// File: rtl/hlsm_pkg.sv
// Shared definitions for the HLSM job sequencer: state encoding and default widths.
package hlsm_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int JOB_CNT_W  = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      RUN    = 2'd2,
      HOLD   = 2'd3
   } state_e;

endpackage

// File: rtl/hlsm_timeout_ctr.sv
// Run-length counter for the kernel watchdog; tc flags the last allowed RUN cycle.
module hlsm_timeout_ctr #(
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic Clk,
   input  logic Rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge Clk) begin
      if (Rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Compare the pre-increment value: RUN cycle n sees cnt == n-1.
   assign tc = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/hlsm_job_sequencer.sv
// Feeds one operand set at a time to an HLSM kernel, captures its results and
// aborts the kernel if Done does not arrive within TIMEOUT run cycles.
module hlsm_job_sequencer
   import hlsm_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 8
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_W-1:0]    in_a,
   input  logic [DATA_W-1:0]    in_b,
   input  logic [DATA_W-1:0]    in_c,
   input  logic [DATA_W-1:0]    in_one,
   output logic                 k_Rst,
   output logic                 k_Start,
   output logic [DATA_W-1:0]    k_a,
   output logic [DATA_W-1:0]    k_b,
   output logic [DATA_W-1:0]    k_c,
   output logic [DATA_W-1:0]    k_one,
   input  logic                 k_Done,
   input  logic [DATA_W-1:0]    k_z,
   input  logic [DATA_W-1:0]    k_x,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    out_z,
   output logic [DATA_W-1:0]    out_x,
   output logic                 out_timeout,
   output logic                 busy,
   output logic [JOB_CNT_W-1:0] job_count,
   output state_e               dbg_state
);

   state_e state, state_nxt;
   logic   accept, capture, abort, abort_pulse, tc;

   // Handshakes: a transfer occurs on a rising edge where valid and ready are both 1;
   // valid never depends on ready, and data is held stable while valid=1 and ready=0.
   assign in_ready  = (state == IDLE);
   assign k_Start   = (state == LAUNCH);
   assign out_valid = (state == HOLD);
   assign busy      = (state != IDLE);
   assign k_Rst     = Rst | abort_pulse;
   assign dbg_state = state;

   always_ff @(posedge Clk) begin
      if (Rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      capture   = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = LAUNCH;
            end
         end
         LAUNCH: state_nxt = RUN;
         RUN: begin
            // Done on the terminal cycle still counts as a normal completion.
            if (k_Done) begin
               capture   = 1'b1;
               state_nxt = HOLD;
            end else if (tc) begin
               abort     = 1'b1;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         k_a         <= '0;
         k_b         <= '0;
         k_c         <= '0;
         k_one       <= '0;
         out_z       <= '0;
         out_x       <= '0;
         out_timeout <= 1'b0;
         abort_pulse <= 1'b0;
         job_count   <= '0;
      end else begin
         abort_pulse <= abort;
         if (accept) begin
            k_a   <= in_a;
            k_b   <= in_b;
            k_c   <= in_c;
            k_one <= in_one;
         end
         if (capture) begin
            out_z       <= k_z;
            out_x       <= k_x;
            out_timeout <= 1'b0;
         end else if (abort) begin
            out_z       <= '0;
            out_x       <= '0;
            out_timeout <= 1'b1;
         end
         if (capture || abort) job_count <= job_count + 1'b1;
      end
   end

   hlsm_timeout_ctr #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) u_timeout_ctr (
      .Clk (Clk),
      .Rst (Rst),
      .clr (state == LAUNCH),
      .en  (state == RUN),
      .tc  (tc)
   );

endmodule

// File: tb/tb_hlsm_job_sequencer.sv
// Directed and randomized jobs against a stub kernel, checked by a result model.
module tb_hlsm_job_sequencer;
   import hlsm_pkg::*;

   localparam int DW = 32;
   localparam int TO = 8;

   logic          Clk, Rst;
   logic          in_valid, in_ready;
   logic [DW-1:0] in_a, in_b, in_c, in_one;
   logic          k_Rst, k_Start, k_Done;
   logic [DW-1:0] k_a, k_b, k_c, k_one, k_z, k_x;
   logic          out_valid, out_ready, out_timeout, busy;
   logic [DW-1:0] out_z, out_x;
   logic [15:0]   job_count;
   state_e        dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_jobs = 0;

   // Stub kernel controls
   int            stub_delay = 0;
   int            stub_cnt   = -1;
   bit            stub_ovr   = 0;
   logic [DW-1:0] stub_oz    = '0;
   logic [DW-1:0] stub_ox    = '0;
   bit            stray_req  = 0;

   hlsm_job_sequencer #(.DATA_W(DW), .TIMEOUT(TO), .CNT_W(8)) dut (
      .Clk(Clk), .Rst(Rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_one(in_one),
      .k_Rst(k_Rst), .k_Start(k_Start),
      .k_a(k_a), .k_b(k_b), .k_c(k_c), .k_one(k_one),
      .k_Done(k_Done), .k_z(k_z), .k_x(k_x),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_z(out_z), .out_x(out_x), .out_timeout(out_timeout),
      .busy(busy), .job_count(job_count), .dbg_state(dbg_state)
   );

   initial begin
      Clk = 0;
      forever #5 Clk = ~Clk;
   end

   // Stub kernel: Done pulses stub_delay cycles after Start (never if 0), z=a+b, x=a-b.
   always @(negedge Clk) begin
      k_Done = 0;
      k_z    = $urandom;
      k_x    = $urandom;
      if (stray_req) begin
         k_Done    = 1;
         stray_req = 0;
      end else if (Rst || k_Rst) begin
         stub_cnt = -1;
      end else if (k_Start) begin
         stub_cnt = 0;
      end else if (stub_cnt >= 0) begin
         stub_cnt++;
         if (stub_cnt == stub_delay) begin
            k_Done   = 1;
            k_z      = stub_ovr ? stub_oz : k_a + k_b;
            k_x      = stub_ovr ? stub_ox : k_a - k_b;
            stub_cnt = -1;
         end
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_job(input logic [DW-1:0] a, b, c, one, input int delay, input int bp,
                          input bit hold_valid, input bit ovr, input logic [DW-1:0] oz, ox);
      bit            to, bad;
      int            e;
      logic [DW-1:0] ez, ex;
      // Reference model: abort when Done would land after the TIMEOUT-th run cycle.
      to = (delay == 0) || (delay > TO);
      e  = to ? TO : delay;
      ez = to ? '0 : (ovr ? oz : a + b);
      ex = to ? '0 : (ovr ? ox : a - b);
      stub_delay = delay; stub_ovr = ovr; stub_oz = oz; stub_ox = ox;
      in_a = a; in_b = b; in_c = c; in_one = one; in_valid = 1;
      check("accept_ready", in_ready, 1);
      @(negedge Clk);
      in_valid = hold_valid;
      in_a = $urandom; in_b = $urandom; in_c = $urandom; in_one = $urandom;
      check("launch_start", {k_Start, in_ready}, 2'b10);
      check("launch_ops", {k_a, k_b, k_c, k_one}, {a, b, c, one});
      bad = 0;
      for (int i = 1; i <= e; i++) begin
         @(negedge Clk);
         if (k_Start !== 0 || out_valid !== 0 || k_Rst !== 0 || in_ready !== 0 || busy !== 1 ||
             {k_a, k_b, k_c, k_one} !== {a, b, c, one}) bad = 1;
      end
      check("run_phase", bad, 0);
      @(negedge Clk);
      exp_jobs++;
      check("res_valid", out_valid, 1);
      check("res_zx", {out_z, out_x}, {ez, ex});
      check("res_timeout", out_timeout, to);
      check("abort_krst", k_Rst, to);
      check("job_count", job_count, exp_jobs[15:0]);
      bad = 0;
      for (int i = 0; i < bp; i++) begin
         @(negedge Clk);
         if (out_valid !== 1 || {out_z, out_x} !== {ez, ex} || out_timeout !== to ||
             in_ready !== 0 || k_Rst !== 0 || {k_a, k_b, k_c, k_one} !== {a, b, c, one}) bad = 1;
      end
      if (bp > 0) check("hold_stable", bad, 0);
      out_ready = 1;
      @(negedge Clk);
      out_ready = 0;
      check("release", {out_valid, in_ready, busy}, 3'b010);
   endtask

   initial begin
      Rst = 1; in_valid = 0; out_ready = 0;
      in_a = '0; in_b = '0; in_c = '0; in_one = '0;
      repeat (3) @(negedge Clk);
      check("rst_ctrl", {in_ready, k_Start, out_valid, out_timeout, busy, k_Rst}, 6'b100001);
      check("rst_data", {k_a, k_b, k_c, k_one, out_z, out_x}, '0);
      check("rst_cnt", job_count, 0);
      check("rst_state", dbg_state, IDLE);
      Rst = 0;
      @(negedge Clk);
      check("krst_release", k_Rst, 0);

      // Stray Done in IDLE
      stray_req = 1;
      repeat (3) @(negedge Clk);
      check("stray_idle", {out_valid, busy, job_count}, 18'd0);

      run_job(32'd7, 32'd3, 32'd0, 32'd1, 5, 10, 0, 0, '0, '0);
      run_job($urandom, $urandom, $urandom, $urandom, 0, 2, 0, 0, '0, '0);
      run_job($urandom, $urandom, $urandom, $urandom, TO, 1, 0, 1, 32'h55, 32'hAA);
      for (int j = 0; j < 6; j++)
         run_job($urandom, $urandom, $urandom, $urandom, $urandom_range(1, 10),
                 $urandom_range(0, 3), 0, 0, '0, '0);

      // Reset during RUN
      stub_delay = 0;
      in_a = $urandom; in_valid = 1;
      @(negedge Clk);
      in_valid = 0;
      repeat (3) @(negedge Clk);
      check("midrun_busy", {busy, dbg_state}, {1'b1, RUN});
      Rst = 1;
      #1;
      check("midrun_krst", k_Rst, 1);
      @(negedge Clk);
      Rst = 0;
      exp_jobs = 0;
      check("midrun_reset", {dbg_state, out_valid, busy, job_count}, {IDLE, 18'd0});
      stray_req = 1;
      repeat (4) @(negedge Clk);
      check("stray_after_rst", {dbg_state, out_valid, job_count}, {IDLE, 17'd0});

      // Back-to-back with in_valid held high
      for (int j = 0; j < 4; j++)
         run_job($urandom, $urandom, $urandom, $urandom, $urandom_range(1, 6), 0, 1, 0, '0, '0);
      in_valid = 0;
      check("b2b_count", job_count, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
